// File: rtl/uart_pkg.sv
// Shared UART receive definitions: parity modes, deframer states and
// configuration checks used by the receive path.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } rx_state_e;

    function automatic bit data_bits_legal(input int n);
        return (n >= 5) && (n <= 9);
    endfunction

endpackage

// File: rtl/uart_rx_shifter.sv
// Right shift register for serial capture: new bits enter at the MSB so the
// first bit received ends up in bit 0 once WIDTH bits have been shifted in.
module uart_rx_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = {serial_in, q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '1;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled start detection, LSB-first data capture,
// optional parity and 1-2 stop bit checks, one-entry output register.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 sample_tick,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_START = ST_START;
    localparam logic [2:0] S_DATA  = ST_DATA;
    localparam logic [2:0] S_PAR   = ST_PAR;
    localparam logic [2:0] S_STOP  = ST_STOP;

    if (!data_bits_legal(DATA_BITS)) begin : g_bad_data_bits
        $error("uart_rx_deframer: DATA_BITS must be in 5..9");
    end

    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 par_acc_q, par_acc_d;
    logic                 stop_acc_q, stop_acc_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic                 shift_en;
    logic [DATA_BITS-1:0] shift_data;
    logic                 done;
    logic                 done_ferr;
    rx_state_e            state_view;

    uart_rx_shifter #(.WIDTH(DATA_BITS)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .en        (shift_en),
        .serial_in (rx),
        .q         (shift_data)
    );

    // Frame sequencing; everything here advances only on sample ticks.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        par_acc_d  = par_acc_q;
        stop_acc_d = stop_acc_q;
        shift_en   = 1'b0;
        done       = 1'b0;
        done_ferr  = 1'b0;
        if (sample_tick) begin
            tick_d = tick_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    tick_d = '0;
                    if (!rx) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d    = '0;
                        bit_d     = '0;
                        par_acc_d = 1'b0;
                        state_d   = rx ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d   = '0;
                        shift_en = 1'b1;
                        if (bit_q == DATA_LAST) begin
                            bit_d      = '0;
                            stop_acc_d = 1'b0;
                            state_d    = (PARITY != PAR_NONE) ? S_PAR : S_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d    = '0;
                        state_d   = S_STOP;
                        par_acc_d = (PARITY == PAR_ODD) ? ~(^shift_data ^ rx)
                                                        : (^shift_data ^ rx);
                    end
                end
                S_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (bit_q == STOP_LAST) begin
                            // Finishing mid-stop-bit leaves half a bit to catch the next start edge.
                            bit_d     = '0;
                            state_d   = S_IDLE;
                            done      = 1'b1;
                            done_ferr = stop_acc_q | ~rx;
                        end else begin
                            bit_d      = bit_q + 1'b1;
                            stop_acc_d = stop_acc_q | ~rx;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    // valid/ready: a character transfers on any cycle with valid && ready;
    // data and flags hold steady while valid is high and ready is low.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (done) begin
            if (!valid_q || ready) begin
                data_d  = shift_data;
                perr_d  = par_acc_q;
                ferr_d  = done_ferr;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            par_acc_q  <= 1'b0;
            stop_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            par_acc_q  <= par_acc_d;
            stop_acc_q <= stop_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign state_view = rx_state_e'(state_q);
    assign busy       = (state_view != ST_IDLE);
    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: three configurations (8N1/16x, 7E2/16x,
// 9O1/8x with a tick every third cycle) driven by directed and random frames.
module tb_uart_rx_deframer;
    import uart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic tick_full;
    logic tick_c;
    logic rx_v    [3];
    logic ready_v [3];
    logic valid_v [3];
    logic perr_v  [3];
    logic ferr_v  [3];
    logic ovr_v   [3];
    logic busy_v  [3];
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic [8:0] data_c;
    logic [8:0] data_v [3];

    int cfg_bits [3] = '{8, 7, 9};
    int cfg_par  [3] = '{PAR_NONE, PAR_EVEN, PAR_ODD};
    int cfg_stop [3] = '{1, 2, 1};
    int cfg_cpb  [3] = '{16, 16, 24};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct packed {
        logic [8:0] d;
        logic       pbit;
        logic [1:0] stop;
    } frame_t;

    logic [10:0] exp_q [$];

    assign data_v[0] = {1'b0, data_a};
    assign data_v[1] = {2'b00, data_b};
    assign data_v[2] = data_c;
    assign tick_c    = (cyc % 3 == 0);

    uart_rx_deframer #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(PAR_NONE), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .rx(rx_v[0]), .sample_tick(tick_full), .data(data_a),
        .valid(valid_v[0]), .ready(ready_v[0]), .parity_err(perr_v[0]), .frame_err(ferr_v[0]),
        .overrun(ovr_v[0]), .busy(busy_v[0])
    );

    uart_rx_deframer #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(PAR_EVEN), .STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .rx(rx_v[1]), .sample_tick(tick_full), .data(data_b),
        .valid(valid_v[1]), .ready(ready_v[1]), .parity_err(perr_v[1]), .frame_err(ferr_v[1]),
        .overrun(ovr_v[1]), .busy(busy_v[1])
    );

    uart_rx_deframer #(.DATA_BITS(9), .OVERSAMPLE(8), .PARITY(PAR_ODD), .STOP_BITS(1)) u_c (
        .clk(clk), .rst(rst), .rx(rx_v[2]), .sample_tick(tick_c), .data(data_c),
        .valid(valid_v[2]), .ready(ready_v[2]), .parity_err(perr_v[2]), .frame_err(ferr_v[2]),
        .overrun(ovr_v[2]), .busy(busy_v[2])
    );

    // Clock/cycle bookkeeping and output monitors.
    int   ovr_cnt [3] = '{0, 0, 0};
    int   rise_cyc_a  = 0;
    logic valid_a_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ovr_v[i] === 1'b1) ovr_cnt[i] <= ovr_cnt[i] + 1;
        end
        if (valid_v[0] === 1'b1 && valid_a_prev !== 1'b1) rise_cyc_a <= cyc;
        valid_a_prev <= valid_v[0];
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, observed running expected finished");
        $fatal(1, "watchdog");
    end

    // Reference model: what a correct receiver reports for a transmitted frame.
    function automatic logic [8:0] data_mask(input int k);
        return 9'((1 << cfg_bits[k]) - 1);
    endfunction

    function automatic logic correct_pbit(input int k, input logic [8:0] d);
        int ones = $countones(d & data_mask(k));
        if (cfg_par[k] == PAR_ODD) return (ones % 2 == 0);
        return (ones % 2 == 1);
    endfunction

    function automatic logic [10:0] model(input int k, input frame_t f);
        logic [8:0] d;
        int         ones;
        logic       pe;
        logic       fe;
        d    = f.d & data_mask(k);
        ones = $countones(d) + (f.pbit ? 1 : 0);
        case (cfg_par[k])
            PAR_ODD:  pe = (ones % 2 == 0);
            PAR_EVEN: pe = (ones % 2 == 1);
            default:  pe = 1'b0;
        endcase
        fe = (f.stop[0] == 1'b0) || (cfg_stop[k] == 2 && f.stop[1] == 1'b0);
        return {pe, fe, d};
    endfunction

    // Driver tasks.
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input int k, input frame_t f);
        int cpb = cfg_cpb[k];
        rx_v[k] = 1'b0;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < cfg_bits[k]; i++) begin
            rx_v[k] = f.d[i];
            repeat (cpb) @(negedge clk);
        end
        if (cfg_par[k] != PAR_NONE) begin
            rx_v[k] = f.pbit;
            repeat (cpb) @(negedge clk);
        end
        for (int i = 0; i < cfg_stop[k]; i++) begin
            rx_v[k] = f.stop[i];
            repeat (cpb) @(negedge clk);
        end
        rx_v[k] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic consume(input int k);
        ready_v[k] = 1'b1;
        @(negedge clk);
        ready_v[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, input int budget, input string tag);
        int n = 0;
        while (valid_v[k] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_in_time"}, 16'(valid_v[k]), 16'd1);
    endtask

    // Scoreboard: pop the expected character and compare against the register.
    task automatic expect_char(input int k, input string tag);
        logic [10:0] e;
        wait_valid(k, 400, tag);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
        check({tag, "_data"}, 16'(data_v[k]), 16'(e[8:0]));
        check({tag, "_frame_err"}, 16'(ferr_v[k]), 16'(e[9]));
        check({tag, "_parity_err"}, 16'(perr_v[k]), 16'(e[10]));
        consume(k);
        check({tag, "_valid_cleared"}, 16'(valid_v[k]), 16'd0);
    endtask

    initial begin
        frame_t f;
        int     start_cyc;
        int     lat;
        int     ov_before;

        rst       = 1'b1;
        tick_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rx_v[k]    = 1'b1;
            ready_v[k] = 1'b0;
        end
        repeat (3) @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            check("rst_data", 16'(data_v[k]), 16'd0);
            check("rst_valid", 16'(valid_v[k]), 16'd0);
            check("rst_parity_err", 16'(perr_v[k]), 16'd0);
            check("rst_frame_err", 16'(ferr_v[k]), 16'd0);
            check("rst_overrun", 16'(ovr_v[k]), 16'd0);
            check("rst_busy", 16'(busy_v[k]), 16'd0);
        end
        rst = 1'b0;
        idle(4);

        // 8N1: 0xA5 with latency check (152 ticks from the first low sample).
        f = '{d: 9'h0A5, pbit: 1'b0, stop: 2'b11};
        start_cyc = cyc;
        send_frame(0, f);
        lat = rise_cyc_a - start_cyc - 1;
        check("a5_latency_152pm1", 16'(lat >= 151 && lat <= 153), 16'd1);
        check("a5_valid", 16'(valid_v[0]), 16'd1);
        check("a5_data", 16'(data_v[0]), 16'h00A5);
        check("a5_parity_err", 16'(perr_v[0]), 16'd0);
        check("a5_frame_err", 16'(ferr_v[0]), 16'd0);
        consume(0);
        check("a5_valid_cleared", 16'(valid_v[0]), 16'd0);
        idle(20);

        // 8N1: 4-tick glitch is rejected at the mid-start sample.
        rx_v[0] = 1'b0;
        idle(4);
        check("glitch_busy_during", 16'(busy_v[0]), 16'd1);
        rx_v[0] = 1'b1;
        idle(5);
        check("glitch_busy_by_tick8", 16'(busy_v[0]), 16'd0);
        idle(200);
        check("glitch_no_valid", 16'(valid_v[0]), 16'd0);
        check("glitch_no_overrun", 16'(ovr_cnt[0]), 16'd0);

        // 8N1: low stop bit delivers with frame_err, next frame is clean.
        f = '{d: 9'h03C, pbit: 1'b0, stop: 2'b10};
        send_frame(0, f);
        check("stoplow_data", 16'(data_v[0]), 16'h003C);
        check("stoplow_frame_err", 16'(ferr_v[0]), 16'd1);
        check("stoplow_parity_err", 16'(perr_v[0]), 16'd0);
        consume(0);
        idle(32);
        f = '{d: 9'h055, pbit: 1'b0, stop: 2'b11};
        send_frame(0, f);
        check("after_stoplow_data", 16'(data_v[0]), 16'h0055);
        check("after_stoplow_frame_err", 16'(ferr_v[0]), 16'd0);
        check("after_stoplow_valid", 16'(valid_v[0]), 16'd1);
        consume(0);
        idle(32);

        // 7E2: 0x41 has two ones, so the even parity bit is 0.
        f = '{d: 9'h041, pbit: 1'b0, stop: 2'b11};
        send_frame(1, f);
        check("b41_data", 16'(data_v[1]), 16'h0041);
        check("b41_parity_err", 16'(perr_v[1]), 16'd0);
        check("b41_frame_err", 16'(ferr_v[1]), 16'd0);
        consume(1);
        idle(32);
        f = '{d: 9'h041, pbit: 1'b1, stop: 2'b11};
        send_frame(1, f);
        check("b41_badpar_data", 16'(data_v[1]), 16'h0041);
        check("b41_badpar_parity_err", 16'(perr_v[1]), 16'd1);
        check("b41_badpar_valid", 16'(valid_v[1]), 16'd1);
        consume(1);
        idle(32);

        // 8N1 with ready low: second frame overruns, third lands on a handshake.
        f = '{d: 9'h011, pbit: 1'b0, stop: 2'b11};
        send_frame(0, f);
        check("ovr_first_data", 16'(data_v[0]), 16'h0011);
        idle(32);
        ov_before = ovr_cnt[0];
        f = '{d: 9'h022, pbit: 1'b0, stop: 2'b11};
        send_frame(0, f);
        idle(4);
        check("ovr_data_kept", 16'(data_v[0]), 16'h0011);
        check("ovr_valid_kept", 16'(valid_v[0]), 16'd1);
        check("ovr_pulse_cycles", 16'(ovr_cnt[0] - ov_before), 16'd1);
        check("ovr_pulse_ended", 16'(ovr_v[0]), 16'd0);
        idle(28);
        ov_before = ovr_cnt[0];
        f = '{d: 9'h033, pbit: 1'b0, stop: 2'b11};
        fork
            send_frame(0, f);
            begin
                repeat (152) @(negedge clk);
                ready_v[0] = 1'b1;
                @(negedge clk);
                ready_v[0] = 1'b0;
                check("samecycle_valid", 16'(valid_v[0]), 16'd1);
                check("samecycle_data", 16'(data_v[0]), 16'h0033);
            end
        join
        idle(2);
        check("samecycle_no_overrun", 16'(ovr_cnt[0] - ov_before), 16'd0);
        consume(0);
        idle(32);

        // 8N1 break: continuous low yields repeated framed zeros.
        rx_v[0] = 1'b0;
        wait_valid(0, 200, "break1");
        check("break1_data", 16'(data_v[0]), 16'd0);
        check("break1_frame_err", 16'(ferr_v[0]), 16'd1);
        consume(0);
        wait_valid(0, 200, "break2");
        check("break2_data", 16'(data_v[0]), 16'd0);
        check("break2_frame_err", 16'(ferr_v[0]), 16'd1);

        // Reset while the third break frame is in DATA; valid is still set.
        idle(40);
        check("pre_rst_busy", 16'(busy_v[0]), 16'd1);
        rst     = 1'b1;
        rx_v[0] = 1'b1;
        @(negedge clk);
        check("midrst_busy", 16'(busy_v[0]), 16'd0);
        check("midrst_valid", 16'(valid_v[0]), 16'd0);
        check("midrst_data", 16'(data_v[0]), 16'd0);
        rst = 1'b0;
        idle(40);
        check("postrst_no_valid", 16'(valid_v[0]), 16'd0);
        f = '{d: 9'h081, pbit: 1'b0, stop: 2'b11};
        send_frame(0, f);
        check("postrst_data", 16'(data_v[0]), 16'h0081);
        check("postrst_frame_err", 16'(ferr_v[0]), 16'd0);
        check("postrst_valid", 16'(valid_v[0]), 16'd1);
        consume(0);
        idle(32);

        // Random frames on all three configurations against the model.
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 3; k++) begin
                f.d       = 9'($urandom_range(0, 511));
                f.pbit    = correct_pbit(k, f.d) ^ ($urandom_range(0, 3) == 0);
                f.stop[0] = ($urandom_range(0, 4) != 0);
                f.stop[1] = ($urandom_range(0, 4) != 0);
                exp_q.push_back(model(k, f));
                send_frame(k, f);
                expect_char(k, "rand");
                idle(2 * cfg_cpb[k]);
            end
        end
        check("rand_no_overrun", 16'(ovr_cnt[1] + ovr_cnt[2]), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Parametrised UART receive deframer: oversamples an already-synchronised serial line, detects start bits, shifts in LSB-first data, and checks optional parity and one or two stop bits. Completed characters go to a one-entry output register with a valid/ready handshake, framing and parity error flags, and overrun signalling. It sits between the rx input synchroniser and the receive FIFO or bus interface, and is driven by the shared baud-tick generator.

## Interface
- DATA_BITS, 8, character width; legal 5..9
- OVERSAMPLE, 16, sample ticks per bit; even, ≥4
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- STOP_BITS, 1, stop bits checked: 1 or 2
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rx  in  1  serial line, already synchronised to clk, idle high
- sample_tick  in  1  one-cycle strobe at baud×OVERSAMPLE
- data  out  DATA_BITS  received character, bit 0 = first data bit on the line
- valid  out  1  data/flag register holds an unconsumed character
- ready  in  1  consumer accepts when valid && ready
- parity_err  out  1  parity mismatch for the character in data; 0 when PARITY=0
- frame_err  out  1  a checked stop bit sampled low for the character in data
- overrun  out  1  one-cycle pulse when a completed character is dropped
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, START, DATA, PAR, STOP. tick_cnt is a counter of width clog2(OVERSAMPLE). bit_cnt counts data or stop bits.
- All state, counter and sampling updates happen only on cycles with sample_tick=1. The output handshake is evaluated every cycle.
- IDLE: when rx=0, go to START and set tick_cnt=0.
- START: at tick_cnt=OVERSAMPLE/2-1 (mid-bit), sample rx.
  - rx=1: false start; return to IDLE with no output.
  - rx=0: go to DATA, tick_cnt=0, bit_cnt=0.
- DATA: at tick_cnt=OVERSAMPLE-1, sample rx.
  - Shift register shifts right with rx into the MSB (bit DATA_BITS-1), so bit 0 ends up holding the first data bit received.
  - After DATA_BITS samples, go to PAR if PARITY≠0, otherwise go to STOP.
- PAR: sample at tick_cnt=OVERSAMPLE-1.
  - Odd mode error: XOR of data bits and parity bit equals 0.
  - Even mode error: XOR of data bits and parity bit equals 1.
- STOP: sample at tick_cnt=OVERSAMPLE-1 for each stop bit.
  - Accumulate frame error if any stop bit is sampled 0.
  - On the last stop bit, complete the character and return directly to IDLE. This happens mid-bit, which allows resynchronisation.
- Completion behaviour:
  - Output register empty or being consumed this cycle: load data, parity_err and frame_err; valid=1.
  - Output register full and not consumed: drop the new character, keep the old contents, pulse overrun.
- Handshake: valid && ready clears valid on the next edge. A completion in the same cycle as a handshake loads and keeps valid=1 (no overrun).
- Errored characters are still delivered. The flags qualify data.

## Timing
- Reset values:
  - state=IDLE, shift register all ones, tick_cnt=0, bit_cnt=0.
  - data=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
- Reset mid-frame abandons the frame immediately; no partial output.
- valid and overrun assert on the clk edge after the sample_tick cycle that samples the final stop bit.
- Latency from the start-bit falling edge to valid, in ticks: OVERSAMPLE/2 + (DATA_BITS + P + STOP_BITS)×OVERSAMPLE, where P=1 if parity is enabled, else 0. Add ±1 tick of edge-detection uncertainty.
- rx held low (break): each frame fails stop, is delivered with frame_err=1, then the block re-arms in IDLE. A continuous low line produces repeated framed characters of 0.
- sample_tick asserted every cycle is legal.

## Structure
- Shared uart_pkg holds:
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN
  - the state enum
  - a DATA_BITS range check function
- One sub-module: uart_rx_shifter, a WIDTH-parameterised right shift register with serial_in into the MSB, en, rst to all ones, and parallel output. It is instantiated for data capture.
- FSM, counters, error logic and the output register stay in the top module.

## Test plan
- Config 8N1, OVERSAMPLE=16, tick every cycle. Send 0xA5 → data=0xA5, valid=1, both error flags 0. valid rises 152±1 cycles after the start edge.
- Config 7E2. Send 0x41 with a correct even parity bit → parity_err=0. Repeat with the parity bit flipped → parity_err=1 and data=0x41.
- Config 8N1. Drive a 4-tick low glitch on rx → no valid, busy returns to 0 by tick 8.
- Config 8N1. Send 0x3C with the stop bit low → data=0x3C, frame_err=1. A following 0x55 is received cleanly.
- Config 8N1 with ready=0. Send 0x11 then 0x22 → data stays 0x11 and overrun pulses for exactly 1 cycle. Then raise ready in the completion cycle of a third frame, 0x33 → data=0x33, no overrun.
- Assert rst in the middle of the DATA state → busy=0, valid=0 on the next edge. The next frame, 0x81, is received correctly.
